// File: rtl/eth_mdio_phy_model.sv
`timescale 1ns/1ps
// Clause 22 MDIO responder with a 32 x 16 PHY register file, oversampling MDC/MDIO
// on the system clock and driving the pad through an out/enable pair.
module eth_mdio_phy_model #(
  parameter logic [4:0] pPhy_Addr     = 5'd0,
  parameter int         pSync_Stages  = 2,
  parameter int         pPreamble_Len = 32
) (
  input  logic        Clk,
  input  logic        Rstn,
  input  logic        MDC,
  input  logic        MDIO_In,
  output logic        MDIO_Out,
  output logic        MDIO_Oe,
  output logic        Reg_Wr_Strobe,
  output logic [4:0]  Reg_Wr_Addr,
  output logic [15:0] Reg_Wr_Data,
  output logic        Frame_Err
);

  localparam int CntW = $clog2(pPreamble_Len + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ST    = 3'd1;
  localparam logic [2:0] S_OP    = 3'd2;
  localparam logic [2:0] S_PHYAD = 3'd3;
  localparam logic [2:0] S_REGAD = 3'd4;
  localparam logic [2:0] S_TA    = 3'd5;
  localparam logic [2:0] S_RD    = 3'd6;
  localparam logic [2:0] S_WR    = 3'd7;

  localparam logic [15:0] R0_WR_MASK = 16'h3100;

  function automatic logic [15:0] reg_default(input logic [4:0] a);
    case (a)
      5'd0:    reg_default = 16'h3100;
      5'd1:    reg_default = 16'h782D;
      5'd2:    reg_default = 16'h0007;
      5'd3:    reg_default = 16'hC0F1;
      5'd4:    reg_default = 16'h01E1;
      default: reg_default = 16'h0000;
    endcase
  endfunction

  logic [pSync_Stages-1:0] mdc_sync_q;
  logic [pSync_Stages-1:0] mdio_sync_q;
  logic                    mdc_hist_q;
  logic                    mdc_s, mdio_s, mdc_rise, mdc_fall;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] pre_cnt_q, pre_cnt_d;
  logic [4:0]      bit_cnt_q, bit_cnt_d;
  logic            op_first_q, op_first_d;
  logic            op_rd_q, op_rd_d;
  logic [4:0]      phyad_q, phyad_d;
  logic [4:0]      regad_q, regad_d;
  logic [15:0]     data_q, data_d;
  logic            oe_q, oe_d, out_q, out_d;
  logic            strobe_q, strobe_d, err_q, err_d;
  logic [4:0]      wr_addr_q, wr_addr_d;
  logic [15:0]     wr_data_q, wr_data_d;
  logic            commit, pre_full, addr_match;
  logic [15:0]     rdata;
  logic [15:0]     regs_q [32];

  assign mdc_s      = mdc_sync_q[pSync_Stages-1];
  assign mdio_s     = mdio_sync_q[pSync_Stages-1];
  assign mdc_rise   = mdc_s & ~mdc_hist_q;
  assign mdc_fall   = ~mdc_s & mdc_hist_q;
  assign pre_full   = (pre_cnt_q >= CntW'(pPreamble_Len));
  assign addr_match = (phyad_q == pPhy_Addr);
  assign rdata      = regs_q[regad_q];

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      mdc_sync_q  <= '0;
      mdio_sync_q <= '1;
      mdc_hist_q  <= 1'b0;
    end else begin
      mdc_sync_q  <= {mdc_sync_q[pSync_Stages-2:0], MDC};
      mdio_sync_q <= {mdio_sync_q[pSync_Stages-2:0], MDIO_In};
      mdc_hist_q  <= mdc_s;
    end
  end

  // Bits are sampled on MDC rise; pad drive only ever changes on MDC fall.
  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    op_first_d = op_first_q;
    op_rd_d    = op_rd_q;
    phyad_d    = phyad_q;
    regad_d    = regad_q;
    data_d     = data_q;
    oe_d       = oe_q;
    out_d      = out_q;
    strobe_d   = 1'b0;
    err_d      = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    commit     = 1'b0;
    case (state_q)
      S_IDLE: if (mdc_rise) begin
        if (mdio_s) begin
          if (!pre_full) pre_cnt_d = pre_cnt_q + CntW'(1);
        end else begin
          pre_cnt_d = '0;
          if (pre_full) state_d = S_ST;
        end
      end
      S_ST: if (mdc_rise) begin
        if (mdio_s) begin
          state_d   = S_OP;
          bit_cnt_d = 5'd0;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_OP: if (mdc_rise) begin
        if (bit_cnt_q == 5'd0) begin
          op_first_d = mdio_s;
          bit_cnt_d  = 5'd1;
        end else begin
          bit_cnt_d = 5'd0;
          if (op_first_q != mdio_s) begin
            op_rd_d = op_first_q;
            state_d = S_PHYAD;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_PHYAD: if (mdc_rise) begin
        phyad_d = {phyad_q[3:0], mdio_s};
        if (bit_cnt_q == 5'd4) begin
          bit_cnt_d = 5'd0;
          state_d   = S_REGAD;
        end else bit_cnt_d = bit_cnt_q + 5'd1;
      end
      S_REGAD: if (mdc_rise) begin
        regad_d = {regad_q[3:0], mdio_s};
        if (bit_cnt_q == 5'd4) begin
          bit_cnt_d = 5'd0;
          state_d   = S_TA;
        end else bit_cnt_d = bit_cnt_q + 5'd1;
      end
      S_TA: begin
        if (mdc_rise) begin
          if (bit_cnt_q == 5'd1) begin
            bit_cnt_d = 5'd0;
            state_d   = op_rd_q ? S_RD : S_WR;
          end else bit_cnt_d = 5'd1;
        end else if (mdc_fall && bit_cnt_q == 5'd1 && op_rd_q && addr_match) begin
          oe_d  = 1'b1;
          out_d = 1'b0;
        end
      end
      S_RD: if (mdc_fall) begin
        // A mismatched frame walks the same bit count with the pad released.
        if (bit_cnt_q == 5'd16) begin
          oe_d      = 1'b0;
          out_d     = 1'b1;
          bit_cnt_d = 5'd0;
          state_d   = S_IDLE;
        end else begin
          if (bit_cnt_q == 5'd0) begin
            if (oe_q) out_d = rdata[15];
            data_d = {rdata[14:0], 1'b0};
          end else begin
            if (oe_q) out_d = data_q[15];
            data_d = {data_q[14:0], 1'b0};
          end
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      S_WR: if (mdc_rise) begin
        data_d = {data_q[14:0], mdio_s};
        if (bit_cnt_q == 5'd15) begin
          bit_cnt_d = 5'd0;
          state_d   = S_IDLE;
          if (addr_match) begin
            commit    = 1'b1;
            strobe_d  = 1'b1;
            wr_addr_d = regad_q;
            wr_data_d = data_d;
          end
        end else bit_cnt_d = bit_cnt_q + 5'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      state_q    <= S_IDLE;
      pre_cnt_q  <= '0;
      bit_cnt_q  <= 5'd0;
      op_first_q <= 1'b0;
      op_rd_q    <= 1'b0;
      phyad_q    <= 5'd0;
      regad_q    <= 5'd0;
      data_q     <= 16'h0000;
      oe_q       <= 1'b0;
      out_q      <= 1'b1;
      strobe_q   <= 1'b0;
      err_q      <= 1'b0;
      wr_addr_q  <= 5'd0;
      wr_data_q  <= 16'h0000;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      op_first_q <= op_first_d;
      op_rd_q    <= op_rd_d;
      phyad_q    <= phyad_d;
      regad_q    <= regad_d;
      data_q     <= data_d;
      oe_q       <= oe_d;
      out_q      <= out_d;
      strobe_q   <= strobe_d;
      err_q      <= err_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // r1..r3 are read-only; r0 bit15 reloads every register and is never stored.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= reg_default(5'(i));
    end else if (commit) begin
      if (regad_q == 5'd0 && wr_data_d[15]) begin
        for (int i = 0; i < 32; i++) regs_q[i] <= reg_default(5'(i));
      end else if (regad_q == 5'd0) begin
        regs_q[0] <= wr_data_d & R0_WR_MASK;
      end else if (regad_q > 5'd3) begin
        regs_q[regad_q] <= wr_data_d;
      end
    end
  end

  assign MDIO_Out      = out_q;
  assign MDIO_Oe       = oe_q;
  assign Reg_Wr_Strobe = strobe_q;
  assign Reg_Wr_Addr   = wr_addr_q;
  assign Reg_Wr_Data   = wr_data_q;
  assign Frame_Err     = err_q;

endmodule

// File: tb/tb_eth_mdio_phy_model.sv
`timescale 1ns/1ps
// Directed bench for eth_mdio_phy_model: table of MDIO frames plus hand-written
// preamble, frame-error and mid-frame reset sequences.
module tb_eth_mdio_phy_model;

  logic        Clk = 1'b0;
  logic        Rstn = 1'b0;
  logic        MDC = 1'b0;
  logic        mdio_drv = 1'b1;
  logic        mdio_bus;
  logic        MDIO_Out, MDIO_Oe, Reg_Wr_Strobe, Frame_Err;
  logic [4:0]  Reg_Wr_Addr;
  logic [15:0] Reg_Wr_Data;

  int errors = 0;
  int checks = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;

  always #5 Clk = ~Clk;

  // Open-drain style bus: the PHY wins while it enables its driver.
  assign mdio_bus = MDIO_Oe ? MDIO_Out : mdio_drv;

  eth_mdio_phy_model #(.pPhy_Addr(5'd0), .pSync_Stages(2), .pPreamble_Len(32)) dut (
    .Clk(Clk), .Rstn(Rstn), .MDC(MDC), .MDIO_In(mdio_bus),
    .MDIO_Out(MDIO_Out), .MDIO_Oe(MDIO_Oe), .Reg_Wr_Strobe(Reg_Wr_Strobe),
    .Reg_Wr_Addr(Reg_Wr_Addr), .Reg_Wr_Data(Reg_Wr_Data), .Frame_Err(Frame_Err)
  );

  always @(negedge Clk) begin
    if (Reg_Wr_Strobe) strobe_cnt++;
    if (Frame_Err) err_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    mdio_drv = b;
    MDC = 1'b0;
    repeat (8) @(negedge Clk);
    MDC = 1'b1;
    repeat (8) @(negedge Clk);
  endtask

  // One full frame; rst_at >= 0 asserts Rstn at that bit's sample point and aborts.
  task automatic run_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                           input logic [4:0] rg, input logic [15:0] wd, input int rst_at,
                           output logic [15:0] rd, output int oe_cnt, output logic ta0_oe,
                           output logic ta1_out, output logic pre_oe, output logic post_oe);
    logic bits [0:127];
    int n;
    n = 0;
    rd = 16'h0; oe_cnt = 0; ta0_oe = 1'b0; ta1_out = 1'b1; pre_oe = 1'b0; post_oe = 1'b1;
    for (int i = 0; i < pre; i++) begin bits[n] = 1'b1; n++; end
    bits[n] = 1'b0; n++;
    bits[n] = 1'b1; n++;
    bits[n] = op[1]; n++;
    bits[n] = op[0]; n++;
    for (int i = 4; i >= 0; i--) begin bits[n] = phy[i]; n++; end
    for (int i = 4; i >= 0; i--) begin bits[n] = rg[i]; n++; end
    bits[n] = 1'b1; n++;
    bits[n] = (op == 2'b01) ? 1'b0 : 1'b1; n++;
    for (int i = 15; i >= 0; i--) begin bits[n] = (op == 2'b01) ? wd[i] : 1'b1; n++; end
    for (int k = 0; k < n; k++) begin
      mdio_drv = bits[k];
      MDC = 1'b0;
      repeat (8) @(negedge Clk);
      if (k == rst_at) begin
        pre_oe = MDIO_Oe;
        Rstn = 1'b0;
        #1;
        post_oe = MDIO_Oe;
        break;
      end
      if (MDIO_Oe) oe_cnt++;
      if (k == pre + 14) ta0_oe = MDIO_Oe;
      if (k == pre + 15) ta1_out = MDIO_Out;
      if (k >= pre + 16) rd = {rd[14:0], mdio_bus};
      MDC = 1'b1;
      repeat (8) @(negedge Clk);
    end
  endtask

  typedef struct packed {
    logic        wr;
    logic [4:0]  phy;
    logic [4:0]  rg;
    logic [15:0] data;
    logic        chk;
    logic [4:0]  exp_oe;
    logic        exp_strobe;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  initial begin
    logic [15:0] rd;
    int oe_cnt, s0, e0;
    logic ta0_oe, ta1_out, pre_oe, post_oe;

    vecs[0]  = '{1'b0, 5'd0, 5'd2,  16'h0007, 1'b1, 5'd17, 1'b0};
    vecs[1]  = '{1'b0, 5'd0, 5'd0,  16'h3100, 1'b1, 5'd17, 1'b0};
    vecs[2]  = '{1'b0, 5'd0, 5'd1,  16'h782D, 1'b1, 5'd17, 1'b0};
    vecs[3]  = '{1'b0, 5'd0, 5'd3,  16'hC0F1, 1'b1, 5'd17, 1'b0};
    vecs[4]  = '{1'b0, 5'd0, 5'd4,  16'h01E1, 1'b1, 5'd17, 1'b0};
    vecs[5]  = '{1'b0, 5'd0, 5'd5,  16'h0000, 1'b1, 5'd17, 1'b0};
    vecs[6]  = '{1'b1, 5'd0, 5'd4,  16'h0061, 1'b0, 5'd0,  1'b1};
    vecs[7]  = '{1'b0, 5'd0, 5'd4,  16'h0061, 1'b1, 5'd17, 1'b0};
    vecs[8]  = '{1'b0, 5'd5, 5'd2,  16'h0000, 1'b0, 5'd0,  1'b0};
    vecs[9]  = '{1'b0, 5'd0, 5'd2,  16'h0007, 1'b1, 5'd17, 1'b0};
    vecs[10] = '{1'b1, 5'd5, 5'd4,  16'h1234, 1'b0, 5'd0,  1'b0};
    vecs[11] = '{1'b0, 5'd0, 5'd4,  16'h0061, 1'b1, 5'd17, 1'b0};
    vecs[12] = '{1'b1, 5'd0, 5'd1,  16'h0000, 1'b0, 5'd0,  1'b1};
    vecs[13] = '{1'b0, 5'd0, 5'd1,  16'h782D, 1'b1, 5'd17, 1'b0};
    vecs[14] = '{1'b1, 5'd0, 5'd0,  16'h1100, 1'b0, 5'd0,  1'b1};
    vecs[15] = '{1'b0, 5'd0, 5'd0,  16'h1100, 1'b1, 5'd17, 1'b0};
    vecs[16] = '{1'b1, 5'd0, 5'd0,  16'h8000, 1'b0, 5'd0,  1'b1};
    vecs[17] = '{1'b0, 5'd0, 5'd4,  16'h01E1, 1'b1, 5'd17, 1'b0};
    vecs[18] = '{1'b0, 5'd0, 5'd0,  16'h3100, 1'b1, 5'd17, 1'b0};
    vecs[19] = '{1'b1, 5'd0, 5'd31, 16'hBEEF, 1'b0, 5'd0,  1'b1};
    vecs[20] = '{1'b0, 5'd0, 5'd31, 16'hBEEF, 1'b1, 5'd17, 1'b0};

    repeat (4) @(negedge Clk);
    check("rst_mdio_out", 32'(MDIO_Out), 32'd1);
    check("rst_mdio_oe", 32'(MDIO_Oe), 32'd0);
    check("rst_strobe", 32'(Reg_Wr_Strobe), 32'd0);
    check("rst_frame_err", 32'(Frame_Err), 32'd0);
    check("rst_wr_addr", 32'(Reg_Wr_Addr), 32'd0);
    check("rst_wr_data", 32'(Reg_Wr_Data), 32'd0);
    Rstn = 1'b1;
    repeat (4) @(negedge Clk);

    for (int v = 0; v < NV; v++) begin
      s0 = strobe_cnt;
      e0 = err_cnt;
      run_frame(32, vecs[v].wr ? 2'b01 : 2'b10, vecs[v].phy, vecs[v].rg, vecs[v].data, -1,
                rd, oe_cnt, ta0_oe, ta1_out, pre_oe, post_oe);
      check($sformatf("v%0d_oe_bits", v), 32'(oe_cnt), 32'(vecs[v].exp_oe));
      check($sformatf("v%0d_frame_err", v), 32'(err_cnt - e0), 32'd0);
      if (vecs[v].wr) begin
        check($sformatf("v%0d_strobes", v), 32'(strobe_cnt - s0), 32'(vecs[v].exp_strobe));
        if (vecs[v].exp_strobe) begin
          check($sformatf("v%0d_wr_addr", v), 32'(Reg_Wr_Addr), 32'(vecs[v].rg));
          check($sformatf("v%0d_wr_data", v), 32'(Reg_Wr_Data), 32'(vecs[v].data));
        end
      end else begin
        check($sformatf("v%0d_ta0_oe", v), 32'(ta0_oe), 32'd0);
        if (vecs[v].chk) check($sformatf("v%0d_rdata", v), 32'(rd), 32'(vecs[v].data));
        if (vecs[v].exp_oe != 5'd0) check($sformatf("v%0d_ta1_out", v), 32'(ta1_out), 32'd0);
        check($sformatf("v%0d_no_strobe", v), 32'(strobe_cnt - s0), 32'd0);
      end
      $display("frame %0d: %s phy=%0d reg=%0d data=0x%04h oe_bits=%0d rd=0x%04h",
               v, vecs[v].wr ? "WR" : "RD", vecs[v].phy, vecs[v].rg, vecs[v].data, oe_cnt, rd);
    end

    // 31-bit preamble must be ignored without an error.
    e0 = err_cnt;
    run_frame(31, 2'b10, 5'd0, 5'd2, 16'h0, -1, rd, oe_cnt, ta0_oe, ta1_out, pre_oe, post_oe);
    check("short_pre_oe_bits", 32'(oe_cnt), 32'd0);
    check("short_pre_frame_err", 32'(err_cnt - e0), 32'd0);
    $display("short preamble read: oe_bits=%0d", oe_cnt);

    // ST = 00 after a full preamble.
    e0 = err_cnt;
    for (int i = 0; i < 32; i++) send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    check("st00_frame_err", 32'(err_cnt - e0), 32'd1);
    $display("ST=00 frame: err_pulses=%0d", err_cnt - e0);

    // OP = 11 after a valid ST.
    e0 = err_cnt;
    for (int i = 0; i < 32; i++) send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    check("op11_frame_err", 32'(err_cnt - e0), 32'd1);
    $display("OP=11 frame: err_pulses=%0d", err_cnt - e0);

    run_frame(32, 2'b10, 5'd0, 5'd2, 16'h0, -1, rd, oe_cnt, ta0_oe, ta1_out, pre_oe, post_oe);
    check("after_err_rdata", 32'(rd), 32'h0007);
    check("after_err_oe_bits", 32'(oe_cnt), 32'd17);
    $display("read after errors: rd=0x%04h oe_bits=%0d", rd, oe_cnt);

    // Change r0 and r4, then reset asynchronously during the 8th read data bit.
    run_frame(32, 2'b01, 5'd0, 5'd0, 16'h0100, -1, rd, oe_cnt, ta0_oe, ta1_out, pre_oe, post_oe);
    run_frame(32, 2'b01, 5'd0, 5'd4, 16'h0042, -1, rd, oe_cnt, ta0_oe, ta1_out, pre_oe, post_oe);
    run_frame(32, 2'b10, 5'd0, 5'd0, 16'h0, 32 + 16 + 7, rd, oe_cnt, ta0_oe, ta1_out, pre_oe, post_oe);
    check("midrst_oe_before", 32'(pre_oe), 32'd1);
    check("midrst_oe_async", 32'(post_oe), 32'd0);
    check("midrst_wr_addr", 32'(Reg_Wr_Addr), 32'd0);
    $display("reset mid read: oe before=%0d after=%0d", pre_oe, post_oe);
    MDC = 1'b0;
    mdio_drv = 1'b1;
    repeat (3) @(negedge Clk);
    Rstn = 1'b1;
    repeat (4) @(negedge Clk);
    run_frame(32, 2'b10, 5'd0, 5'd0, 16'h0, -1, rd, oe_cnt, ta0_oe, ta1_out, pre_oe, post_oe);
    check("postrst_r0", 32'(rd), 32'h3100);
    check("postrst_oe_bits", 32'(oe_cnt), 32'd17);
    $display("read r0 after reset: rd=0x%04h", rd);
    run_frame(32, 2'b10, 5'd0, 5'd4, 16'h0, -1, rd, oe_cnt, ta0_oe, ta1_out, pre_oe, post_oe);
    check("postrst_r4", 32'(rd), 32'h01E1);
    $display("read r4 after reset: rd=0x%04h", rd);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
